// File: rtl/data_bus_responder.sv
// ---------------------------------------------------------------------------
// data_bus_responder
//   Responder end of the CPU data-memory port. Every access is decoded to one
//   of three targets: a word RAM, a UART transmitter fed by a TX FIFO, or a
//   free-running cycle counter. Loads are answered combinationally so a
//   single-cycle core can consume the data in the same cycle.
//
//   Address map (word address = dataAddr[31:2]):
//     0x0000_0000 .. RAM_WORDS*4-1  RAM, full 32-bit word read/write
//     0x8000_0000                   TXDATA  write pushes writeData[7:0]; reads 0
//     0x8000_0004                   STATUS  {27'b0, ovf, busy, empty, full, 1'b0}
//                                           write with writeData[4]=1 clears ovf
//     0x8000_0008                   CYCLE   cycle count; any write loads 0
//     anything else                 reads 0, writes ignored
//
// Ports
//   clk        in   1   clock, all state updates on the rising edge
//   n_reset    in   1   asynchronous active-low reset
//   dataAddr   in   32  byte address from the CPU, [1:0] ignored
//   writeData  in   32  store data
//   we         in   1   store strobe, sampled on the rising edge
//   readData   out  32  load data, combinational from dataAddr and state
//   uart_tx    out  1   serial output, 8N1, LSB first, idle high, registered
// ---------------------------------------------------------------------------
module data_bus_responder #(
    parameter int RAM_WORDS    = 256,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [31:0] dataAddr,
    input  logic [31:0] writeData,
    input  logic        we,
    output logic [31:0] readData,
    output logic        uart_tx
);

    localparam int RAM_AW  = $clog2(RAM_WORDS);
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int TIMER_W = $clog2(CLKS_PER_BIT);

    localparam logic [29:0]        TXDATA_WORD = 30'h2000_0000;
    localparam logic [29:0]        STATUS_WORD = 30'h2000_0001;
    localparam logic [29:0]        CYCLE_WORD  = 30'h2000_0002;
    localparam logic [FIFO_AW:0]   FIFO_FULL   = (FIFO_AW + 1)'(FIFO_DEPTH);
    localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} txStateT;

    // ---------------- address decode ----------------
    logic [29:0]       wordAddr;
    logic [RAM_AW-1:0] ramIdx;
    logic              ramHit, txDataHit, statusHit, cycleHit;
    logic              unusedAddrBits;

    assign wordAddr       = dataAddr[31:2];
    assign ramIdx         = wordAddr[RAM_AW-1:0];
    assign ramHit         = (wordAddr[29:RAM_AW] == '0);
    assign txDataHit      = (wordAddr == TXDATA_WORD);
    assign statusHit      = (wordAddr == STATUS_WORD);
    assign cycleHit       = (wordAddr == CYCLE_WORD);
    assign unusedAddrBits = ^dataAddr[1:0];

    // ---------------- state ----------------
    logic [31:0]        ram [RAM_WORDS];
    logic [7:0]         fifoMem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] rdPtr, wrPtr;
    logic [FIFO_AW:0]   fifoCount;
    logic               ovf;
    logic [31:0]        cycleCount, cycleNext;

    txStateT            txState;
    logic [TIMER_W-1:0] bitTimer;
    logic [2:0]         bitIdx;
    logic [7:0]         shiftReg;

    logic full, empty, busy, push, pop, pushAccept, ovfSet, ovfClear;

    assign full       = (fifoCount == FIFO_FULL);
    assign empty      = (fifoCount == '0);
    assign busy       = (txState != IDLE);
    assign push       = we && txDataHit;
    assign pop        = (txState == IDLE) && !empty;
    // A pop frees the slot the push needs, so push+pop is legal when full.
    assign pushAccept = push && (!full || pop);
    assign ovfSet     = push && full && !pop;
    assign ovfClear   = we && statusHit && writeData[4];
    assign cycleNext  = (we && cycleHit) ? 32'd0 : cycleCount + 32'd1;

    // ---------------- load path ----------------
    always_comb begin
        // NOTE: default first so every path assigns readData -- no latch.
        readData = '0;
        if (ramHit)
            readData = ram[ramIdx];
        else if (statusHit)
            readData = {27'b0, ovf, busy, empty, full, 1'b0};
        else if (cycleHit)
            readData = cycleCount;
    end

    // ---------------- storage arrays ----------------
    // NOTE: RAM and FIFO storage have no reset; validity is tracked by
    // the FIFO pointers, and RAM contents are undefined until written.
    always_ff @(posedge clk) begin
        if (we && ramHit)
            ram[ramIdx] <= writeData;
        if (pushAccept)
            fifoMem[wrPtr] <= writeData[7:0];
    end

    // ---------------- FIFO control, overflow flag, cycle counter ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rdPtr      <= '0;
            wrPtr      <= '0;
            fifoCount  <= '0;
            ovf        <= 1'b0;
            cycleCount <= '0;
        end else begin
            cycleCount <= cycleNext;
            if (pushAccept)
                wrPtr <= wrPtr + FIFO_AW'(1);
            if (pop)
                rdPtr <= rdPtr + FIFO_AW'(1);
            case ({pushAccept, pop})
                2'b10:   fifoCount <= fifoCount + (FIFO_AW + 1)'(1);
                2'b01:   fifoCount <= fifoCount - (FIFO_AW + 1)'(1);
                default: fifoCount <= fifoCount;
            endcase
            // Setting the flag takes priority over a same-cycle clear.
            if (ovfSet)
                ovf <= 1'b1;
            else if (ovfClear)
                ovf <= 1'b0;
        end
    end

    // ---------------- UART transmitter ----------------
    // uart_tx is updated together with the state so it changes exactly on
    // bit boundaries and never glitches.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            txState  <= IDLE;
            uart_tx  <= 1'b1;
            bitTimer <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
        end else begin
            case (txState)
                IDLE: begin
                    uart_tx <= 1'b1;
                    if (pop) begin
                        shiftReg <= fifoMem[rdPtr];
                        bitTimer <= '0;
                        txState  <= START;
                        uart_tx  <= 1'b0;
                    end
                end
                START: begin
                    if (bitTimer == TIMER_LAST) begin
                        bitTimer <= '0;
                        bitIdx   <= '0;
                        txState  <= DATA;
                        uart_tx  <= shiftReg[0];
                    end else begin
                        bitTimer <= bitTimer + TIMER_W'(1);
                    end
                end
                DATA: begin
                    if (bitTimer == TIMER_LAST) begin
                        bitTimer <= '0;
                        if (bitIdx == 3'd7) begin
                            txState <= STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            // shiftReg[1] is the next bit once the register shifts.
                            bitIdx   <= bitIdx + 3'd1;
                            shiftReg <= shiftReg >> 1;
                            uart_tx  <= shiftReg[1];
                        end
                    end else begin
                        bitTimer <= bitTimer + TIMER_W'(1);
                    end
                end
                STOP: begin
                    if (bitTimer == TIMER_LAST) begin
                        bitTimer <= '0;
                        txState  <= IDLE;
                    end else begin
                        bitTimer <= bitTimer + TIMER_W'(1);
                    end
                    uart_tx <= 1'b1;
                end
                default: begin
                    txState <= IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_data_bus_responder
//   Bench for data_bus_responder with CLKS_PER_BIT=4, FIFO_DEPTH=4,
//   RAM_WORDS=16. A serial receiver decodes uart_tx into bytes; a queue-based
//   model predicts load data and transmitted bytes for random traffic.
// ---------------------------------------------------------------------------
module tb_data_bus_responder;

    localparam int CPB   = 4;
    localparam int FD    = 4;
    localparam int RW    = 16;
    localparam int FRAME = 10 * CPB;

    localparam logic [31:0] TXDATA = 32'h8000_0000;
    localparam logic [31:0] STATUS = 32'h8000_0004;
    localparam logic [31:0] CYCLE  = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [31:0] dataAddr = '0;
    logic [31:0] writeData = '0;
    logic        we = 1'b0;
    logic [31:0] readData;
    logic        uart_tx;

    data_bus_responder #(
        .RAM_WORDS   (RW),
        .FIFO_DEPTH  (FD),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .dataAddr (dataAddr),
        .writeData(writeData),
        .we       (we),
        .readData (readData),
        .uart_tx  (uart_tx)
    );

    always #5 clk = ~clk;

    int nVectors = 0;
    int nMiscompares = 0;

    // ---------------- check / bus helpers ----------------
    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        dataAddr  = a;
        writeData = d;
        we        = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic checkRead(input string name, input logic [31:0] a, input logic [31:0] expected);
        we       = 1'b0;
        dataAddr = a;
        #1;
        check(name, readData, expected);
    endtask

    // ---------------- serial receiver ----------------
    byte unsigned rxQ[$];
    int          rxFrameErrors = 0;
    logic [7:0]  rxByte;

    initial begin
        forever begin
            @(negedge clk);
            if (n_reset === 1'b1 && uart_tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int j = 0; j < 8; j++) begin
                    repeat (CPB) @(negedge clk);
                    rxByte[j] = uart_tx;
                end
                repeat (CPB) @(negedge clk);
                if (uart_tx !== 1'b1)
                    rxFrameErrors++;
                rxQ.push_back(rxByte);
            end
        end
    end

    byte unsigned expBytes[$];

    task automatic checkRx(input string name);
        check({name, " frame errors"}, rxFrameErrors, 0);
        check({name, " byte count"}, rxQ.size(), expBytes.size());
        foreach (expBytes[i])
            check($sformatf("%s byte %0d", name, i),
                  (i < rxQ.size()) ? 32'(rxQ[i]) : 32'hxxxx_xxxx, 32'(expBytes[i]));
    endtask

    task automatic clearRx();
        rxQ.delete();
        expBytes.delete();
        rxFrameErrors = 0;
    endtask

    // Expected line level k edges after the store edge of a single byte.
    function automatic logic txLevel(input logic [7:0] b, input int k);
        if (k < 1)           return 1'b1;
        if (k < 1 + CPB)     return 1'b0;
        if (k < 1 + 9 * CPB) return b[(k - 1 - CPB) / CPB];
        return 1'b1;
    endfunction

    // ---------------- behavioural model for random traffic ----------------
    byte unsigned mq[$];
    byte unsigned mExp[$];
    int           mRem;       // cycles until the transmitter is free again
    logic         mOvf;
    logic [31:0]  mCycle;
    logic [31:0]  mRam [RW];
    bit           mValid [RW];

    task automatic modelRead(input logic [31:0] a, output logic [31:0] v, output bit ok);
        ok = 1'b1;
        v  = '0;
        if ((a >> 2) < RW) begin
            ok = mValid[a[5:2]];
            v  = mRam[a[5:2]];
        end else if ((a >> 2) == (STATUS >> 2)) begin
            v = {27'b0, mOvf, mRem > 0, mq.size() == 0, mq.size() == FD, 1'b0};
        end else if ((a >> 2) == (CYCLE >> 2)) begin
            v = mCycle;
        end
    endtask

    task automatic modelEdge(input logic [31:0] a, input logic [31:0] d, input logic w);
        bit popNow, pushNow, clrNow, dropNow;
        popNow  = (mRem == 0) && (mq.size() != 0);
        pushNow = w && ((a >> 2) == (TXDATA >> 2));
        clrNow  = w && ((a >> 2) == (STATUS >> 2)) && d[4];
        dropNow = pushNow && (mq.size() == FD) && !popNow;
        if (popNow)
            mExp.push_back(mq.pop_front());
        if (pushNow && !dropNow)
            mq.push_back(d[7:0]);
        if (dropNow)
            mOvf = 1'b1;
        else if (clrNow)
            mOvf = 1'b0;
        if (popNow)
            mRem = FRAME;
        else if (mRem > 0)
            mRem--;
        mCycle = (w && ((a >> 2) == (CYCLE >> 2))) ? 32'd0 : mCycle + 32'd1;
        if (w && ((a >> 2) < RW)) begin
            mRam[a[5:2]]   = d;
            mValid[a[5:2]] = 1'b1;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRead;
    } busVecT;

    busVecT vecs [16];

    logic [31:0] rAddr, rData, rExp;
    logic        rWe;
    bit          rOk, found;
    int          lows;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0,         32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 32'h0000_000B, 32'h0,         32'hDEAD_BEEF};
        vecs[3]  = '{1'b0, 32'h0000_0040, 32'h0,         32'h0};
        vecs[4]  = '{1'b1, 32'h0000_0000, 32'h0123_4567, 32'h0};
        vecs[5]  = '{1'b1, 32'h0000_003C, 32'hA5A5_5A5A, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_0048, 32'hFFFF_FFFF, 32'h0};
        vecs[7]  = '{1'b1, 32'h8000_0048, 32'h1111_1111, 32'h0};
        vecs[8]  = '{1'b0, 32'h0000_0008, 32'h0,         32'hDEAD_BEEF};
        vecs[9]  = '{1'b0, 32'h0000_0002, 32'h0,         32'h0123_4567};
        vecs[10] = '{1'b0, 32'h0000_003F, 32'h0,         32'hA5A5_5A5A};
        vecs[11] = '{1'b0, 32'h8000_0000, 32'h0,         32'h0};
        vecs[12] = '{1'b0, 32'h8000_000C, 32'h0,         32'h0};
        vecs[13] = '{1'b1, 32'h8000_000C, 32'h0000_0055, 32'h0};
        vecs[14] = '{1'b0, 32'h8000_0004, 32'h0,         32'h0000_0004};
        vecs[15] = '{1'b0, 32'hFFFF_FFF8, 32'h0,         32'h0};

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("reset uart_tx", uart_tx, 1'b1);
        checkRead("reset STATUS", STATUS, 32'h04);
        checkRead("reset CYCLE", CYCLE, 32'h0);

        // ---- CYCLE counter ----
        @(negedge clk);
        n_reset = 1'b1;
        repeat (10) tick();
        checkRead("cycle after 10 edges", CYCLE, 32'd10);
        busWrite(CYCLE, 32'h1234_5678);
        checkRead("cycle after write edge", CYCLE, 32'd0);
        tick();
        checkRead("cycle one edge after write", CYCLE, 32'd1);
        force dut.cycleNext = 32'hFFFF_FFFF;
        tick();
        release dut.cycleNext;
        checkRead("cycle forced max", CYCLE, 32'hFFFF_FFFF);
        tick();
        checkRead("cycle wrap", CYCLE, 32'd0);
        tick();
        checkRead("cycle after wrap", CYCLE, 32'd1);

        // ---- RAM and decode table ----
        foreach (vecs[i]) begin
            dataAddr  = vecs[i].addr;
            writeData = vecs[i].wdata;
            we        = vecs[i].wr;
            #1;
            if (!vecs[i].wr)
                check($sformatf("table[%0d] read 0x%08h", i, vecs[i].addr), readData, vecs[i].expRead);
            tick();
            we = 1'b0;
        end

        // ---- single frame, exact timing ----
        clearRx();
        busWrite(TXDATA, 32'h55);
        for (int k = 0; k < 45; k++) begin
            check($sformatf("tx 0x55 level at edge +%0d", k), uart_tx, txLevel(8'h55, k));
            if (k == 0)  checkRead("status before start", STATUS, 32'h00);
            if (k == 1)  checkRead("status during frame", STATUS, 32'h0C);
            if (k == 41) checkRead("status after frame", STATUS, 32'h04);
            tick();
        end
        expBytes.push_back(8'h55);
        checkRx("single frame rx");

        // ---- overflow ----
        clearRx();
        for (int i = 1; i <= 6; i++)
            busWrite(TXDATA, 32'(i));
        checkRead("status after overflow", STATUS, 32'h1A);
        busWrite(STATUS, 32'h0F);
        checkRead("ovf kept without bit4", STATUS, 32'h1A);
        busWrite(STATUS, 32'h10);
        checkRead("ovf cleared", STATUS, 32'h0A);
        for (int c = 0; c < 500 && rxQ.size() < 5; c++)
            tick();
        repeat (60) tick();
        for (int i = 1; i <= 5; i++)
            expBytes.push_back(8'(i));
        checkRx("overflow rx");
        checkRead("status after drain", STATUS, 32'h04);

        // ---- push on the pop cycle while full ----
        clearRx();
        for (int i = 0; i < 5; i++)
            busWrite(TXDATA, 32'hA0 + 32'(i));
        checkRead("status full mid-frame", STATUS, 32'h0A);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            we = 1'b0;
            dataAddr = STATUS;
            #1;
            if (readData[3] === 1'b0)
                found = 1'b1;
            else
                tick();
        end
        check("pop cycle reached", found, 1'b1);
        check("status on pop cycle", readData, 32'h02);
        busWrite(TXDATA, 32'hA5);
        checkRead("status after push+pop", STATUS, 32'h0A);
        for (int c = 0; c < 6 * (FRAME + 1) + 100 && rxQ.size() < 6; c++)
            tick();
        repeat (20) tick();
        for (int i = 0; i < 6; i++)
            expBytes.push_back(8'hA0 + 8'(i));
        checkRx("push+pop rx");

        // ---- reset mid-frame ----
        clearRx();
        busWrite(TXDATA, 32'hA5);
        busWrite(TXDATA, 32'h3C);
        repeat (17) tick();
        check("tx during data bit 3", uart_tx, 1'b0);
        dataAddr = STATUS;
        #1;
        n_reset = 1'b0;
        #1;
        check("tx high on async reset", uart_tx, 1'b1);
        check("status on async reset", readData, 32'h04);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_reset = 1'b1;
        repeat (45) tick();
        clearRx();
        lows = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (uart_tx !== 1'b1)
                lows++;
        end
        check("no frame after reset", lows, 0);
        check("no byte after reset", rxQ.size(), 0);
        checkRead("status after reset idle", STATUS, 32'h04);

        // ---- random traffic against the model ----
        n_reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_reset = 1'b1;
        clearRx();
        mq.delete();
        mExp.delete();
        mRem   = 0;
        mOvf   = 1'b0;
        mCycle = '0;
        foreach (mValid[i]) mValid[i] = 1'b0;

        for (int n = 0; n < 800; n++) begin
            rData = $urandom;
            rWe   = 1'b0;
            case ($urandom_range(0, 15))
                0, 1, 2, 3: begin
                    rAddr = (32'($urandom_range(0, RW - 1)) << 2) | 32'($urandom_range(0, 3));
                    rWe   = 1'b1;
                end
                4, 5, 6: rAddr = (32'($urandom_range(0, RW - 1)) << 2) | 32'($urandom_range(0, 3));
                7, 8: begin
                    rAddr = TXDATA;
                    rWe   = ($urandom_range(0, 3) != 0);
                end
                10: begin
                    rAddr = STATUS;
                    rWe   = 1'b1;
                end
                11: rAddr = CYCLE;
                12: begin
                    rAddr = CYCLE;
                    rWe   = ($urandom_range(0, 3) == 0);
                end
                13: begin
                    case ($urandom_range(0, 2))
                        0:       rAddr = 32'h40 + (32'($urandom_range(0, 255)) << 2);
                        1:       rAddr = 32'h8000_000C + (32'($urandom_range(0, 60)) << 2);
                        default: rAddr = 32'h4000_0000 | (32'($urandom) & 32'h3FFF_FFFF);
                    endcase
                    rWe = 1'($urandom_range(0, 1));
                end
                default: rAddr = STATUS;
            endcase
            dataAddr  = rAddr;
            writeData = rData;
            we        = rWe;
            #1;
            modelRead(rAddr, rExp, rOk);
            if (rOk)
                check($sformatf("random[%0d] read 0x%08h", n, rAddr), readData, rExp);
            modelEdge(rAddr, rData, rWe);
            tick();
        end
        we = 1'b0;
        dataAddr = STATUS;
        for (int c = 0; c < 2000 && (mq.size() != 0 || mRem != 0); c++) begin
            modelEdge(STATUS, 32'h0, 1'b0);
            tick();
        end
        repeat (10) tick();
        expBytes = mExp;
        checkRx("random rx");
        checkRead("status after random drain", STATUS, {27'b0, mOvf, 4'b0100});

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
